// File: rtl/xornor_pkg.sv
// xornor_pkg: shared state type, vector count and golden XorNor helpers
package xornor_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  localparam int NUM_VECTORS = 8;
  function automatic logic [1:0] xornor_expect(input logic a, input logic b, input logic c);
    return {a ^ b, ~((a ^ b) | c)};
  endfunction
  function automatic logic [2:0] vec_map(input logic [2:0] idx, input logic gray);
    return gray ? idx ^ (idx >> 1) : idx;
  endfunction
endpackage

// File: rtl/xornor_sweep_checker_if.sv
// xornor_sweep_checker_if: stimulus, response and verdict signals of the sweep checker
interface xornor_sweep_checker_if #(parameter int ERR_W = 4);
  logic start;
  logic a;
  logic b;
  logic c;
  logic x;
  logic y;
  logic busy;
  logic done;
  logic pass;
  logic [ERR_W-1:0] err_count;
  logic fail_valid;
  logic [2:0] fail_vec;
  modport master(input start, x, y, output a, b, c, busy, done, pass, err_count, fail_valid, fail_vec);
  modport slave(output start, x, y, input a, b, c, busy, done, pass, err_count, fail_valid, fail_vec);
endinterface

// File: rtl/xornor_settle_timer.sv
// xornor_settle_timer: loadable down-counter whose tick marks the 1->0 edge
module xornor_settle_timer #(
  parameter int CYCLES = 3,
  localparam int W = $clog2(CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);
  logic [W-1:0] cnt;
  // reload on request, otherwise count down and rest at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= W'(CYCLES);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign tick = cnt == W'(1);
endmodule

// File: rtl/xornor_sweep_checker.sv
// xornor_sweep_checker: drives all 8 {a,b,c} vectors into XorNor and checks x/y after settling
module xornor_sweep_checker
  import xornor_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3,
  parameter int ERR_W = 4,
  parameter int GRAY_ORDER = 0
) (
  input logic clk,
  input logic rst_n,
  xornor_sweep_checker_if.master bus
);
  state_t state, state_nx;
  logic [2:0] idx, vec, fail_vec;
  logic [ERR_W-1:0] err;
  logic fail_valid, tick, accept, check, last, mism, load;
  xornor_settle_timer #(.CYCLES(SETTLE_CYCLES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .tick(tick)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // a start outside SETTLE begins a sweep; the last check ends it
  always_comb state_nx = accept ? SETTLE : (check && last) ? DONE : state;
  // control strobes; start while busy is simply not accepted
  always_comb begin
    accept = bus.start && state != SETTLE;
    check = state == SETTLE && tick;
    last = idx == 3'(NUM_VECTORS - 1);
    mism = check && ({bus.x, bus.y} != xornor_expect(vec[2], vec[1], vec[0]));
    load = accept || (check && !last);
  end
  // vector stepping, saturating error count and first-failure capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      vec <= '0;
      err <= '0;
      fail_valid <= 1'b0;
      fail_vec <= '0;
    end else if (accept) begin
      idx <= '0;
      vec <= vec_map(3'd0, GRAY_ORDER != 0);
      err <= '0;
      fail_valid <= 1'b0;
      fail_vec <= '0;
    end else if (check) begin
      if (mism && err != {ERR_W{1'b1}}) err <= err + 1'b1;
      if (mism && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_vec <= vec;
      end
      if (!last) begin
        idx <= idx + 1'b1;
        vec <= vec_map(idx + 1'b1, GRAY_ORDER != 0);
      end
    end
  assign {bus.a, bus.b, bus.c} = vec;
  assign bus.busy = state == SETTLE;
  assign bus.done = state == DONE;
  assign bus.pass = state == DONE && err == '0;
  assign bus.err_count = err;
  assign bus.fail_valid = fail_valid;
  assign bus.fail_vec = fail_vec;
endmodule

// File: tb/tb_xornor_sweep_checker.sv
// tb_xornor_sweep_checker: directed sweeps against fault-free and faulty XorNor models
module tb_xornor_sweep_checker;
  logic clk = 0;
  logic rst_n = 0;
  logic fault = 0;
  int chk = 0;
  int fails = 0;
  logic [2:0] gt [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  always #5 clk = ~clk;
  xornor_sweep_checker_if m_if();
  xornor_sweep_checker_if #(.ERR_W(2)) e_if();
  xornor_sweep_checker_if g_if();
  xornor_sweep_checker dut (.clk(clk), .rst_n(rst_n), .bus(m_if.master));
  xornor_sweep_checker #(.ERR_W(2)) dut_e (.clk(clk), .rst_n(rst_n), .bus(e_if.master));
  xornor_sweep_checker #(.GRAY_ORDER(1)) dut_g (.clk(clk), .rst_n(rst_n), .bus(g_if.master));
  // XorNor models: main one with optional Y stuck-at-0, one with X inverted, one fault-free
  assign m_if.x = m_if.a ^ m_if.b;
  assign m_if.y = fault ? 1'b0 : ~((m_if.a ^ m_if.b) | m_if.c);
  assign e_if.x = ~(e_if.a ^ e_if.b);
  assign e_if.y = ~((e_if.a ^ e_if.b) | e_if.c);
  assign g_if.x = g_if.a ^ g_if.b;
  assign g_if.y = ~((g_if.a ^ g_if.b) | g_if.c);
  logic [2:0] m_abc, e_abc, g_abc;
  logic [11:0] m_st, g_st;
  logic [9:0] e_st;
  assign m_abc = {m_if.a, m_if.b, m_if.c};
  assign e_abc = {e_if.a, e_if.b, e_if.c};
  assign g_abc = {g_if.a, g_if.b, g_if.c};
  assign m_st = {m_if.busy, m_if.done, m_if.pass, m_if.err_count, m_if.fail_valid, m_if.fail_vec};
  assign e_st = {e_if.busy, e_if.done, e_if.pass, e_if.err_count, e_if.fail_valid, e_if.fail_vec};
  assign g_st = {g_if.busy, g_if.done, g_if.pass, g_if.err_count, g_if.fail_valid, g_if.fail_vec};

  task automatic go(input int which);
    @(negedge clk);
    if (which == 0) m_if.start = 1;
    else if (which == 1) e_if.start = 1;
    else g_if.start = 1;
    @(posedge clk);
    #1;
    m_if.start = 0;
    e_if.start = 0;
    g_if.start = 0;
  endtask

  task automatic test_reset;
    #12;
    chk++; if ({m_abc, m_st} !== 15'd0) begin fails++; $display("FAIL reset_main got=%h exp=0", {m_abc, m_st}); end
    chk++; if ({e_abc, e_st} !== 13'd0) begin fails++; $display("FAIL reset_e got=%h exp=0", {e_abc, e_st}); end
    chk++; if ({g_abc, g_st} !== 15'd0) begin fails++; $display("FAIL reset_g got=%h exp=0", {g_abc, g_st}); end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_sweep;
    go(0);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) begin repeat (3) @(posedge clk); #1; end
      chk++; if ({m_abc, m_if.busy, m_if.done} !== {3'(k), 2'b10}) begin fails++; $display("FAIL sweep_vec%0d got=%b exp=%b", k, {m_abc, m_if.busy, m_if.done}, {3'(k), 2'b10}); end
    end
    repeat (2) @(posedge clk); #1;
    chk++; if (m_if.done !== 1'b0) begin fails++; $display("FAIL sweep_done_early got=%b exp=0", m_if.done); end
    @(posedge clk); #1;
    chk++; if ({m_abc, m_st} !== {3'b111, 12'b011_0000_0_000}) begin fails++; $display("FAIL sweep_end got=%b exp=%b", {m_abc, m_st}, {3'b111, 12'b011_0000_0_000}); end
  endtask

  task automatic test_y_stuck;
    fault = 1;
    go(0);
    chk++; if (m_st !== 12'b100_0000_0_000) begin fails++; $display("FAIL ystuck_start got=%b exp=%b", m_st, 12'b100_0000_0_000); end
    repeat (3) @(posedge clk); #1;
    chk++; if ({m_abc, m_st} !== {3'b001, 12'b100_0001_1_000}) begin fails++; $display("FAIL ystuck_first got=%b exp=%b", {m_abc, m_st}, {3'b001, 12'b100_0001_1_000}); end
    repeat (18) @(posedge clk); #1;
    chk++; if ({m_abc, m_st} !== {3'b111, 12'b100_0010_1_000}) begin fails++; $display("FAIL ystuck_second got=%b exp=%b", {m_abc, m_st}, {3'b111, 12'b100_0010_1_000}); end
    repeat (3) @(posedge clk); #1;
    chk++; if ({m_abc, m_st} !== {3'b111, 12'b010_0010_1_000}) begin fails++; $display("FAIL ystuck_end got=%b exp=%b", {m_abc, m_st}, {3'b111, 12'b010_0010_1_000}); end
    fault = 0;
  endtask

  task automatic test_back_to_back;
    go(0);
    chk++; if (m_st !== 12'b100_0000_0_000) begin fails++; $display("FAIL b2b_clear got=%b exp=%b", m_st, 12'b100_0000_0_000); end
    repeat (4) @(posedge clk);
    @(negedge clk) m_if.start = 1;
    @(posedge clk); #1;
    m_if.start = 0;
    chk++; if ({m_abc, m_if.busy} !== 4'b0011) begin fails++; $display("FAIL b2b_ignored got=%b exp=0011", {m_abc, m_if.busy}); end
    repeat (18) @(posedge clk); #1;
    chk++; if ({m_abc, m_if.busy, m_if.done} !== 5'b11110) begin fails++; $display("FAIL b2b_pre_done got=%b exp=11110", {m_abc, m_if.busy, m_if.done}); end
    @(posedge clk); #1;
    chk++; if (m_st !== 12'b011_0000_0_000) begin fails++; $display("FAIL b2b_done got=%b exp=%b", m_st, 12'b011_0000_0_000); end
    @(posedge clk);
    @(negedge clk) m_if.start = 1;
    @(posedge clk); #1;
    m_if.start = 0;
    chk++; if ({m_abc, m_st} !== {3'b000, 12'b100_0000_0_000}) begin fails++; $display("FAIL b2b_restart got=%b exp=%b", {m_abc, m_st}, {3'b000, 12'b100_0000_0_000}); end
    repeat (24) @(posedge clk); #1;
    chk++; if (m_st !== 12'b011_0000_0_000) begin fails++; $display("FAIL b2b_second_done got=%b exp=%b", m_st, 12'b011_0000_0_000); end
  endtask

  task automatic test_x_inverted;
    go(1);
    chk++; if (e_st !== 10'b100_00_0_000) begin fails++; $display("FAIL xinv_start got=%b exp=%b", e_st, 10'b100_00_0_000); end
    repeat (6) @(posedge clk); #1;
    chk++; if (e_st !== 10'b100_10_1_000) begin fails++; $display("FAIL xinv_two got=%b exp=%b", e_st, 10'b100_10_1_000); end
    repeat (6) @(posedge clk); #1;
    chk++; if (e_st !== 10'b100_11_1_000) begin fails++; $display("FAIL xinv_sat got=%b exp=%b", e_st, 10'b100_11_1_000); end
    repeat (12) @(posedge clk); #1;
    chk++; if ({e_abc, e_st} !== {3'b111, 10'b010_11_1_000}) begin fails++; $display("FAIL xinv_end got=%b exp=%b", {e_abc, e_st}, {3'b111, 10'b010_11_1_000}); end
  endtask

  task automatic test_gray;
    logic [2:0] prev;
    prev = 3'b000;
    go(2);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) begin repeat (3) @(posedge clk); #1; end
      chk++; if (g_abc !== gt[k]) begin fails++; $display("FAIL gray_vec%0d got=%b exp=%b", k, g_abc, gt[k]); end
      if (k != 0) begin
        chk++; if ($countones(g_abc ^ prev) != 1) begin fails++; $display("FAIL gray_step%0d got=%b prev=%b exp one toggle", k, g_abc, prev); end
      end
      prev = g_abc;
    end
    repeat (3) @(posedge clk); #1;
    chk++; if ({g_abc, g_st} !== {3'b100, 12'b011_0000_0_000}) begin fails++; $display("FAIL gray_end got=%b exp=%b", {g_abc, g_st}, {3'b100, 12'b011_0000_0_000}); end
  endtask

  task automatic test_mid_reset;
    fault = 1;
    go(0);
    repeat (9) @(posedge clk); #1;
    chk++; if ({m_abc, m_st} !== {3'b011, 12'b100_0001_1_000}) begin fails++; $display("FAIL rst_before got=%b exp=%b", {m_abc, m_st}, {3'b011, 12'b100_0001_1_000}); end
    #2 rst_n = 0;
    #1;
    chk++; if ({m_abc, m_st} !== 15'd0) begin fails++; $display("FAIL rst_async got=%b exp=0", {m_abc, m_st}); end
    rst_n = 1;
    fault = 0;
    repeat (5) @(posedge clk); #1;
    chk++; if ({m_abc, m_st} !== 15'd0) begin fails++; $display("FAIL rst_idle got=%b exp=0", {m_abc, m_st}); end
    go(0);
    chk++; if ({m_abc, m_st} !== {3'b000, 12'b100_0000_0_000}) begin fails++; $display("FAIL rst_restart got=%b exp=%b", {m_abc, m_st}, {3'b000, 12'b100_0000_0_000}); end
  endtask

  initial begin
    m_if.start = 0;
    e_if.start = 0;
    g_if.start = 0;
    test_reset;
    test_sweep;
    test_y_stuck;
    test_back_to_back;
    test_x_inverted;
    test_gray;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end
endmodule
